// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl
// ----------------
// Sequencer that computes Q = k*P by MSB-first double-and-add over all 256
// scalar bits, delegating every group operation to an external point-add
// unit. A doubling is issued as the request R+R.
//
// Build option:
//   SCALAR_MULT_CONST_TIME_EN  when defined, an add request is issued for
//                              every bit and its result is discarded for
//                              clear bits (512 requests per operation,
//                              independent of k). When undefined, adds are
//                              issued only for set bits.
//
// Parameters:
//   ID_X, ID_Y, ID_Z  coordinates of the identity point (initial R)
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start                      start request (ignored while busy)
//   i_k                          256-bit scalar
//   i_px, i_py, i_pz             base point P
//   o_busy                       operation in progress
//   o_done                       one-cycle completion pulse
//   o_qx, o_qy, o_qz             result Q, held until the next completion
//   o_pa_start                   point-add request pulse
//   o_pa_x1 .. o_pa_z1           addend 1 (registered, stable while pending)
//   o_pa_x2 .. o_pa_z2           addend 2 (registered, stable while pending)
//   i_pa_x3, i_pa_y3, i_pa_z3    point-add result
//   i_pa_finished                point-add completion pulse
module scalar_mult_ctrl #(
  parameter logic [255:0] ID_X = 256'd0,
  parameter logic [255:0] ID_Y = 256'd1,
  parameter logic [255:0] ID_Z = 256'd1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [255:0] i_k,
  input  logic [255:0] i_px,
  input  logic [255:0] i_py,
  input  logic [255:0] i_pz,
  output logic         o_busy,
  output logic         o_done,
  output logic [255:0] o_qx,
  output logic [255:0] o_qy,
  output logic [255:0] o_qz,
  output logic         o_pa_start,
  output logic [255:0] o_pa_x1,
  output logic [255:0] o_pa_y1,
  output logic [255:0] o_pa_z1,
  output logic [255:0] o_pa_x2,
  output logic [255:0] o_pa_y2,
  output logic [255:0] o_pa_z2,
  input  logic [255:0] i_pa_x3,
  input  logic [255:0] i_pa_y3,
  input  logic [255:0] i_pa_z3,
  input  logic         i_pa_finished
);

`ifdef SCALAR_MULT_CONST_TIME_EN
  localparam logic CONST_TIME = 1'b1;
`else
  localparam logic CONST_TIME = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DBL_REQ,
    S_DBL_WAIT,
    S_ADD_REQ,
    S_ADD_WAIT,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   idx_q, idx_d;
  logic [255:0] k_q, k_d;
  logic [255:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
  logic [255:0] rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pa_start_q, pa_start_d;
  logic [255:0] x1_q, x1_d, y1_q, y1_d, z1_q, z1_d;
  logic [255:0] x2_q, x2_d, y2_q, y2_d, z2_q, z2_d;
  logic [255:0] qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
  logic         k_bit;

  assign k_bit = k_q[idx_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    k_d        = k_q;
    px_d       = px_q;
    py_d       = py_q;
    pz_d       = pz_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    rz_d       = rz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pa_start_d = 1'b0;
    x1_d       = x1_q;
    y1_d       = y1_q;
    z1_d       = z1_q;
    x2_d       = x2_q;
    y2_d       = y2_q;
    z2_d       = z2_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    qz_d       = qz_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_d     = i_k;
          px_d    = i_px;
          py_d    = i_py;
          pz_d    = i_pz;
          rx_d    = ID_X;
          ry_d    = ID_Y;
          rz_d    = ID_Z;
          idx_d   = 8'd255;
          busy_d  = 1'b1;
          state_d = S_DBL_REQ;
        end
      end

      S_DBL_REQ: begin
        pa_start_d = 1'b1;
        x1_d       = rx_q;
        y1_d       = ry_q;
        z1_d       = rz_q;
        x2_d       = rx_q;
        y2_d       = ry_q;
        z2_d       = rz_q;
        state_d    = S_DBL_WAIT;
      end

      S_DBL_WAIT: begin
        if (i_pa_finished) begin
          rx_d = i_pa_x3;
          ry_d = i_pa_y3;
          rz_d = i_pa_z3;
          if (k_bit || CONST_TIME) begin
            state_d = S_ADD_REQ;
          end else if (idx_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 8'd1;
            state_d = S_DBL_REQ;
          end
        end
      end

      S_ADD_REQ: begin
        pa_start_d = 1'b1;
        x1_d       = rx_q;
        y1_d       = ry_q;
        z1_d       = rz_q;
        x2_d       = px_q;
        y2_d       = py_q;
        z2_d       = pz_q;
        state_d    = S_ADD_WAIT;
      end

      S_ADD_WAIT: begin
        if (i_pa_finished) begin
          // In constant-time builds the add for a clear bit is a dummy.
          if (k_bit) begin
            rx_d = i_pa_x3;
            ry_d = i_pa_y3;
            rz_d = i_pa_z3;
          end
          if (idx_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 8'd1;
            state_d = S_DBL_REQ;
          end
        end
      end

      S_DONE: begin
        // o_done and the new Q appear together while busy drops.
        qx_d    = rx_q;
        qy_d    = ry_q;
        qz_d    = rz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 8'd0;
      rx_q       <= '0;
      ry_q       <= '0;
      rz_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pa_start_q <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      z1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      z2_q       <= '0;
      qx_q       <= '0;
      qy_q       <= '0;
      qz_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      rz_q       <= rz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pa_start_q <= pa_start_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      z1_q       <= z1_d;
      x2_q       <= x2_d;
      y2_q       <= y2_d;
      z2_q       <= z2_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      qz_q       <= qz_d;
    end
  end

  // Scalar and base point are only meaningful after a start, so they carry
  // no reset.
  always_ff @(posedge i_clk) begin
    k_q  <= k_d;
    px_q <= px_d;
    py_q <= py_d;
    pz_q <= pz_d;
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_qx       = qx_q;
  assign o_qy       = qy_q;
  assign o_qz       = qz_q;
  assign o_pa_start = pa_start_q;
  assign o_pa_x1    = x1_q;
  assign o_pa_y1    = y1_q;
  assign o_pa_z1    = z1_q;
  assign o_pa_x2    = x2_q;
  assign o_pa_y2    = y2_q;
  assign o_pa_z2    = z2_q;

endmodule

// File: doc/scalar_mult_ctrl.md
SCALAR_MULT_CTRL -- requirements
Module: scalar_mult_ctrl

Interface
REQ-001 SHALL have parameter ID_X, default 256'd0: X coordinate of the identity point.
REQ-002 SHALL have parameter ID_Y, default 256'd1: Y coordinate of the identity point.
REQ-003 SHALL have parameter ID_Z, default 256'd1: Z coordinate of the identity point.
REQ-004 SHALL have these ports; the first two are i_clk (input, 1, clock) and i_rst (input, 1, reset, synchronous, active-high):
- i_start  in  1  start request
- i_k  in  256  scalar
- i_px / i_py / i_pz  in  256 each  base point
- o_busy  out  1  operation in progress
- o_done  out  1  one-cycle completion pulse
- o_qx / o_qy / o_qz  out  256 each  result Q = k*P
- o_pa_start  out  1  point-add request pulse
- o_pa_x1 / o_pa_y1 / o_pa_z1  out  256 each  addend 1
- o_pa_x2 / o_pa_y2 / o_pa_z2  out  256 each  addend 2
- i_pa_x3 / i_pa_y3 / i_pa_z3  in  256 each  point-add result
- i_pa_finished  in  1  point-add completion pulse

Function
REQ-005 SHALL be the initiator for the point-add unit: it computes Q = k*P by MSB-first double-and-add over bits 255 down to 0, using only point-add requests. A doubling is the request R+R.
REQ-006 SHALL use the states S_IDLE, S_DBL_REQ, S_DBL_WAIT, S_ADD_REQ, S_ADD_WAIT and S_DONE.
REQ-007 In S_IDLE with i_start=1, SHALL latch i_k and P, set R=(ID_X,ID_Y,ID_Z), set bit index=255, and go to S_DBL_REQ. o_busy SHALL rise the next cycle.
REQ-008 In S_DBL_REQ, SHALL pulse o_pa_start for exactly one cycle with addend1=addend2=R, then go to S_DBL_WAIT.
REQ-009 In S_DBL_WAIT, on i_pa_finished, SHALL load R with the i_pa_* result.
- If k[idx]=1 (or CONST_TIME_EN is defined): go to S_ADD_REQ.
- Otherwise: go to S_DBL_REQ, or to S_DONE when idx=0; idx decrements.
REQ-010 In S_ADD_REQ, SHALL pulse o_pa_start for one cycle with addend1=R and addend2=P, then go to S_ADD_WAIT.
REQ-011 In S_ADD_WAIT, on i_pa_finished, SHALL load R with the result only if k[idx]=1. It SHALL then go to S_DONE if idx=0, otherwise decrement idx and go to S_DBL_REQ.
REQ-012 In S_DONE, SHALL copy R to o_qx/o_qy/o_qz, pulse o_done for one cycle and return to S_IDLE. o_busy SHALL be low in that same cycle.
REQ-013 o_pa_x1..o_pa_z2 SHALL be registered, valid in the o_pa_start cycle, and held stable until i_pa_finished is accepted.
REQ-014 i_pa_finished SHALL be ignored outside the *_WAIT states.
REQ-015 i_start SHALL be ignored while o_busy=1.
REQ-016 o_q* SHALL hold their value until the next S_DONE.
REQ-017 Point-add latency is arbitrary (at least 1 cycle). A finished pulse in the cycle right after o_pa_start SHALL be accepted.
REQ-018 k=0 SHALL yield Q=identity after 256 doublings.

Reset
REQ-019 While i_rst=1, SHALL force state=S_IDLE and drive o_busy=0, o_done=0, o_pa_start=0, all o_pa_* operands=0, o_q*=0, R=0 and idx=0.
REQ-020 Reset asserted mid-operation SHALL abort the operation with no o_done pulse. A late i_pa_finished after reset SHALL be ignored.

Configuration
REQ-021 Macro SCALAR_MULT_CONST_TIME_EN, when defined: an add request SHALL be issued for every bit, and the result SHALL be discarded when k[idx]=0. This gives exactly 512 requests per operation, independent of k.
REQ-022 When SCALAR_MULT_CONST_TIME_EN is undefined: add requests SHALL be issued only for set bits, giving 256+popcount(k) requests.

Verification
Bench setup: ID_X=ID_Y=ID_Z=0; stub adder returns the componentwise sum mod 2^256 with 3-cycle latency.
REQ-023 k=5, P=(7,11,13) -> o_done once, Q=(35,55,65).
- Macro undefined: 258 o_pa_start pulses.
- Macro defined: 512 pulses.
REQ-024 k=0, P=(1,2,3) -> Q=(0,0,0), 256 requests (macro undefined).
REQ-025 k=2^256-1, P=(1,1,1) -> Q=(2^256-1, 2^256-1, 2^256-1), 512 requests.
REQ-026 Stub latency 1 and 40 cycles, k=3, P=(4,4,4) -> Q=(12,12,12). Operands stay stable while each request is outstanding.
REQ-027 i_rst asserted at request 100 of k=9 -> o_busy=0 and no o_done. A fresh start with k=1, P=(9,9,9) -> Q=(9,9,9).
REQ-028 Second i_start while busy and a spurious i_pa_finished in S_IDLE -> both ignored, and the first result is unaffected.
